// File: rtl/aer_spike_encoder_pkg.sv
// Shared constants for the AER spike encoder: FSM encoding, LFSR taps,
// marker-event address and datapath widths.
package aer_spike_encoder_pkg;

  localparam int AER_AW    = 12;  // event address width
  localparam int PIX_W     = 8;   // pixel intensity width
  localparam int PIX_IDX_W = 10;  // pixel index width
  localparam int LFSR_W    = 16;

  // Galois form of x^16+x^14+x^13+x^11+1 (right-shifting)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Address of the end-of-timestep marker event
  localparam logic [AER_AW-1:0] TSTEP_ADDR = 12'hFFF;

  // FSM state encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_CMP   = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_ACKLO = 3'd4;
  localparam logic [2:0] S_TSTEP = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  // One LFSR step
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/aer_spike_encoder_pix_buf.sv
// pix_buf: N x DW simple dual-port RAM, synchronous read with one cycle latency.
module pix_buf #(
  parameter int N  = 784,
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [N];

  // Write port and registered read port; contents are never reset
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/aer_spike_encoder.sv
// aer_spike_encoder: rate-codes a buffered N-pixel sample into AER events over
// T_STEPS timesteps using a 16-bit Galois LFSR and a four-phase REQ/ACK link.
// Optional macro AER_TSTEP_EVENT_EN: emit a 12'hFFF marker event per timestep.
module aer_spike_encoder
  import aer_spike_encoder_pkg::*;
#(
  parameter int               N       = 784,
  parameter int               T_STEPS = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PIX_WE,
  input  logic [PIX_IDX_W-1:0] PIX_WADDR,
  input  logic [PIX_W-1:0]     PIX_WDATA,
  input  logic                 START,
  output logic [AER_AW-1:0]    AERIN_ADDR,
  output logic                 AERIN_REQ,
  input  logic                 AERIN_ACK,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int TW = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;

  logic [2:0]           state_q, state_d;
  logic [PIX_IDX_W-1:0] pix_q, pix_d;
  logic [TW-1:0]        t_q, t_d;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
  logic [AER_AW-1:0]    addr_q, addr_d;
  logic                 req_q, req_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef AER_TSTEP_EVENT_EN
  logic                 mark_q, mark_d;  // marker for this timestep already sent
`endif

  logic             buf_we;
  logic [PIX_W-1:0] pix_rdata;
  logic             last_pix, last_t;

  // Buffer is frozen while a sample is in flight; out-of-range writes dropped
  assign buf_we   = PIX_WE && !busy_q && ({1'b0, PIX_WADDR} < 11'(N));
  assign last_pix = (pix_q == PIX_IDX_W'(N - 1));
  assign last_t   = (t_q == TW'(T_STEPS - 1));

  pix_buf #(.N(N), .AW(PIX_IDX_W), .DW(PIX_W)) u_pix_buf (
    .clk_i   (CLK),
    .we_i    (buf_we),
    .waddr_i (PIX_WADDR),
    .wdata_i (PIX_WDATA),
    .re_i    (state_q == S_RD),
    .raddr_i (pix_q),
    .rdata_o (pix_rdata)
  );

  // Next-state logic for the encoding FSM
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    t_d     = t_q;
    lfsr_d  = lfsr_q;
    addr_d  = addr_q;
    req_d   = req_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef AER_TSTEP_EVENT_EN
    mark_d  = mark_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START && !busy_q) begin
          busy_d  = 1'b1;
          pix_d   = '0;
          t_d     = '0;
          lfsr_d  = SEED;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_CMP;  // read issued, data valid next cycle
      S_CMP: begin
        lfsr_d = lfsr_next(lfsr_q);
        if (pix_rdata > lfsr_q[7:0]) begin
          addr_d  = {2'b00, pix_q};
          req_d   = 1'b1;
          state_d = S_REQ;
        end else if (last_pix) begin
          state_d = S_TSTEP;
        end else begin
          pix_d   = pix_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_REQ: begin
        if (AERIN_ACK) begin
          req_d   = 1'b0;
          state_d = S_ACKLO;
        end
      end
      S_ACKLO: begin
        if (!AERIN_ACK) begin
`ifdef AER_TSTEP_EVENT_EN
          if (mark_q)        state_d = S_TSTEP;
          else
`endif
          if (last_pix)      state_d = S_TSTEP;
          else begin
            pix_d   = pix_q + 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_TSTEP: begin
`ifdef AER_TSTEP_EVENT_EN
        if (!mark_q) begin
          mark_d  = 1'b1;
          addr_d  = TSTEP_ADDR;
          req_d   = 1'b1;
          state_d = S_REQ;
        end else begin
          mark_d = 1'b0;
`endif
          if (last_t) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FIN;
          end else begin
            t_d     = t_q + 1'b1;
            pix_d   = '0;
            state_d = S_RD;
          end
`ifdef AER_TSTEP_EVENT_EN
        end
`endif
      end
      S_FIN:   state_d = S_IDLE;  // DONE is high for exactly this cycle
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      t_q     <= '0;
      lfsr_q  <= SEED;
      addr_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AER_TSTEP_EVENT_EN
      mark_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      t_q     <= t_d;
      lfsr_q  <= lfsr_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef AER_TSTEP_EVENT_EN
      mark_q  <= mark_d;
`endif
    end
  end

  assign AERIN_ADDR = addr_q;
  assign AERIN_REQ  = req_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Directed bench for aer_spike_encoder: instance A (T_STEPS=16) and B (T_STEPS=1)
// share reset and pixel-write inputs; each has its own START and ACK responder.
module tb_aer_spike_encoder;

  localparam int N  = 784;
  localparam int TA = 16;
  localparam int TB = 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        PIX_WE = 1'b0;
  logic [9:0]  PIX_WADDR = '0;
  logic [7:0]  PIX_WDATA = '0;
  logic        START_A = 1'b0, START_B = 1'b0;
  logic        ACK_A = 1'b0, ACK_B = 1'b0;
  logic [11:0] ADDR_A, ADDR_B;
  logic        REQ_A, REQ_B, BUSY_A, BUSY_B, DONE_A, DONE_B;

  always #5 CLK = ~CLK;

  aer_spike_encoder #(.N(N), .T_STEPS(TA), .SEED(16'hACE1)) dut_a (
    .CLK(CLK), .RST(RST), .PIX_WE(PIX_WE), .PIX_WADDR(PIX_WADDR), .PIX_WDATA(PIX_WDATA),
    .START(START_A), .AERIN_ADDR(ADDR_A), .AERIN_REQ(REQ_A), .AERIN_ACK(ACK_A),
    .BUSY(BUSY_A), .DONE(DONE_A));

  aer_spike_encoder #(.N(N), .T_STEPS(TB), .SEED(16'hACE1)) dut_b (
    .CLK(CLK), .RST(RST), .PIX_WE(PIX_WE), .PIX_WADDR(PIX_WADDR), .PIX_WDATA(PIX_WDATA),
    .START(START_B), .AERIN_ADDR(ADDR_B), .AERIN_REQ(REQ_B), .AERIN_ACK(ACK_B),
    .BUSY(BUSY_B), .DONE(DONE_B));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] img [N];
  int exp_q[$], qa[$], qb[$], clean_q[$];

  // Galois step written bit by bit: taps at 15,13,12,10 after the shift
  function automatic logic [15:0] lstep(input logic [15:0] s);
    logic [15:0] r;
    for (int k = 0; k < 15; k++) r[k] = s[k+1];
    r[15] = s[0];
    r[13] = s[14] ^ s[0];
    r[12] = s[13] ^ s[0];
    r[10] = s[11] ^ s[0];
    return r;
  endfunction

  task automatic build_exp(input int tsteps);
    logic [15:0] s;
    s = 16'hACE1;
    exp_q.delete();
    for (int t = 0; t < tsteps; t++) begin
      for (int p = 0; p < N; p++) begin
        if (img[p] > s[7:0]) exp_q.push_back(p);
        s = lstep(s);
      end
`ifdef AER_TSTEP_EVENT_EN
      exp_q.push_back(12'hFFF);
`endif
    end
  endtask

  function automatic int qdiff(input int a[$], input int b[$]);
    int d;
    d = 0;
    for (int k = 0; k < a.size() && k < b.size(); k++) if (a[k] != b[k]) d++;
    return d;
  endfunction

  // ---------------- ACK responders ----------------
  // mode 0: ACK echoes REQ two cycles late; mode 1: ACK raised 2 cycles after
  // REQ and held high for 10 cycles
  logic [1:0] sh_a = '0, sh_b = '0;
  int mode_b = 0, dly_b = 0, hold_b = 0;

  always begin
    @(posedge CLK); #1;
    sh_a  = {sh_a[0], REQ_A};
    ACK_A = sh_a[1];
    sh_b  = {sh_b[0], REQ_B};
    if (mode_b == 0) ACK_B = sh_b[1];
    else if (ACK_B) begin
      if (hold_b == 0) ACK_B = 1'b0; else hold_b--;
    end else if (REQ_B) begin
      dly_b++;
      if (dly_b == 2) begin ACK_B = 1'b1; hold_b = 9; dly_b = 0; end
    end
  end

  // ---------------- protocol monitor / event capture ----------------
  logic [1:0]  req_v, ack_v;
  logic [11:0] addr_v [2];
  assign req_v = {REQ_B, REQ_A};
  assign ack_v = {ACK_B, ACK_A};
  assign addr_v[0] = ADDR_A;
  assign addr_v[1] = ADDR_B;

  logic        req_p [2] = '{1'b0, 1'b0};
  logic        ack_p [2] = '{1'b0, 1'b0};
  logic [11:0] addr_p [2] = '{12'd0, 12'd0};
  logic        rst_p = 1'b0;
  int v_rise [2] = '{0, 0};  // REQ rose while ACK high
  int v_hs   [2] = '{0, 0};  // REQ did not drop exactly after ACK sampled
  int v_addr [2] = '{0, 0};  // ADDR moved while REQ high or while idle

  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_p && RST) begin
        if (req_v[i] && !req_p[i] && ack_v[i]) v_rise[i]++;
        if (req_p[i] && ack_p[i] && req_v[i]) v_hs[i]++;
        if (req_p[i] && !ack_p[i] && !req_v[i]) v_hs[i]++;
        if (!(req_v[i] && !req_p[i]) && addr_v[i] != addr_p[i]) v_addr[i]++;
      end
      if (req_v[i] && !req_p[i]) begin
        if (i == 0) qa.push_back(int'(addr_v[i]));
        else        qb.push_back(int'(addr_v[i]));
      end
      req_p[i]  = req_v[i];
      ack_p[i]  = ack_v[i];
      addr_p[i] = addr_v[i];
    end
    rst_p = RST;
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill(input logic [7:0] v);
    for (int p = 0; p < N; p++) begin
      @(posedge CLK); #1;
      PIX_WE = 1'b1; PIX_WADDR = 10'(p); PIX_WDATA = v; img[p] = v;
    end
    @(posedge CLK); #1; PIX_WE = 1'b0;
  endtask

  task automatic setpix(input int p, input logic [7:0] v);
    @(posedge CLK); #1;
    PIX_WE = 1'b1; PIX_WADDR = 10'(p); PIX_WDATA = v; img[p] = v;
    @(posedge CLK); #1; PIX_WE = 1'b0;
  endtask

  function automatic logic done_of(input int i);
    return (i == 0) ? DONE_A : DONE_B;
  endfunction

  function automatic logic busy_of(input int i);
    return (i == 0) ? BUSY_A : BUSY_B;
  endfunction

  task automatic set_start(input int i, input logic v);
    if (i == 0) START_A = v; else START_B = v;
  endtask

  // Pulse START, count edges until DONE; at cycle inj re-pulse START and
  // write pixel 5 := 0 (both must be ignored while busy)
  task automatic run(input string tag, input int i, input int limit, input int inj,
                     output int cyc);
    int c;
    c = 0;
    @(posedge CLK); #1; set_start(i, 1'b1);
    @(posedge CLK); #1; set_start(i, 1'b0);
    while (!done_of(i) && c < limit) begin
      @(posedge CLK); #1; c++;
      set_start(i, c == inj);
      PIX_WE    = (c == inj);
      PIX_WADDR = 10'd5;
      PIX_WDATA = 8'd0;
    end
    set_start(i, 1'b0); PIX_WE = 1'b0;
    cyc = c;
    chk({tag, "_in_time"}, int'(c < limit), 1);
    chk({tag, "_busy_at_done"}, int'(busy_of(i)), 0);
    @(posedge CLK); #1;
    chk({tag, "_done_1cyc"}, int'(done_of(i)), 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cyc, bad, k;

    // reset values
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req_a", int'(REQ_A), 0);   chk("rst_addr_a", int'(ADDR_A), 0);
    chk("rst_busy_a", int'(BUSY_A), 0); chk("rst_done_a", int'(DONE_A), 0);
    chk("rst_req_b", int'(REQ_B), 0);   chk("rst_addr_b", int'(ADDR_B), 0);
    chk("rst_busy_b", int'(BUSY_B), 0); chk("rst_done_b", int'(DONE_B), 0);
    RST = 1'b1;

    // all zeros, 16 timesteps: no pixel events, 16*(784*2+1) cycles to DONE
    fill(8'd0);
    qa.delete();
    run("zero", 0, 40000, -1, cyc);
    build_exp(TA);
    chk("zero_events", qa.size(), exp_q.size());
`ifndef AER_TSTEP_EVENT_EN
    chk("zero_events_none", qa.size(), 0);
    chk("zero_cycles", cyc, 16 * (784 * 2 + 1));
`endif

    // all 255, 1 timestep, echo ACK: every pixel except lfsr byte 255
    fill(8'd255);
    qb.delete();
    run("full", 1, 20000, -1, cyc);
    build_exp(TB);
    chk("full_count", qb.size(), exp_q.size());
    chk("full_order", qdiff(qb, exp_q), 0);
    chk("full_first", (qb.size() > 0) ? qb[0] : -1, 0);  // 255 > 0xE1
    chk("full_second", (qb.size() > 1) ? qb[1] : -1, 1); // 255 > 0x70
    chk("full_hs", v_hs[1], 0);

    // only pixel 5 = 128 over 16 timesteps
    fill(8'd0);
    setpix(5, 8'd128);
    qa.delete();
    run("p5", 0, 40000, -1, cyc);
    build_exp(TA);
    chk("p5_count", qa.size(), exp_q.size());
    chk("p5_order", qdiff(qa, exp_q), 0);
    bad = 0;
    foreach (qa[j]) if (qa[j] != 5 && qa[j] != 12'hFFF) bad++;
    chk("p5_only_addr5", bad, 0);
    chk("p5_first", (qa.size() > 0) ? qa[0] : -1, 5);  // t=0: 128 > 0x27
    chk("p5_rise_vs_ack", v_rise[0], 0);
    chk("a_addr_stable", v_addr[0], 0);
    chk("a_hs", v_hs[0], 0);

    // ACK held high 10 cycles; pixel 700 = 200 gives a second candidate event
    setpix(700, 8'd200);
    mode_b = 1; dly_b = 0;
    qb.delete();
    run("hold", 1, 20000, -1, cyc);
    build_exp(TB);
    chk("hold_count", qb.size(), exp_q.size());
    chk("hold_order", qdiff(qb, exp_q), 0);
    chk("hold_first", (qb.size() > 0) ? qb[0] : -1, 5);
    chk("hold_rise_vs_ack", v_rise[1], 0);
    chk("hold_hs", v_hs[1], 0);
    chk("hold_addr_stable", v_addr[1], 0);
    mode_b = 0;
    repeat (3) @(posedge CLK);

    // clean run, then identical run with START and PIX_WE pulsed while busy
    qb.delete();
    run("clean", 1, 20000, -1, cyc);
    clean_q = qb;
    qb.delete();
    run("inj", 1, 20000, 2, cyc);
    chk("inj_count", qb.size(), clean_q.size());
    chk("inj_same", qdiff(qb, clean_q), 0);
    chk("inj_vs_model", qdiff(qb, exp_q), 0);

    // reset while REQ is high, then restart from pixel 0 with SEED
    @(posedge CLK); #1; START_B = 1'b1;
    @(posedge CLK); #1; START_B = 1'b0;
    k = 0;
    while (!REQ_B && k < 3000) begin @(posedge CLK); #1; k++; end
    chk("rstmid_req_seen", int'(REQ_B), 1);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("rstmid_req", int'(REQ_B), 0);
    chk("rstmid_busy", int'(BUSY_B), 0);
    RST = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    qb.delete();
    run("restart", 1, 20000, -1, cyc);
    chk("restart_count", qb.size(), exp_q.size());
    chk("restart_order", qdiff(qb, exp_q), 0);
    chk("b_rise_vs_ack", v_rise[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
